qpsk_frame_scheduler: RTL and testbench

//  Sequences byte frames into the QPSK symbol mapper.
//  - Accepts a byte stream with valid/ready/last.
//  - Prepends a programmable preamble of dibits.
//  - Serialises each payload byte into 4 dibits, MSB pair first.
//  - Drives the mapper's din/din_valid/din_last, with m_ready wired from the mapper's in_ready.
//  - Enforces an idle gap between frames.

---
 rtl/qpsk_frame_scheduler_if.sv | 21 ++
 rtl/qpsk_frame_scheduler.sv | 147 ++++++++++++++
 tb/tb_qpsk_frame_scheduler.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qpsk_frame_scheduler_if.sv
// rtl/qpsk_frame_scheduler_if.sv - byte-in / dibit-out handshake bundle for the QPSK frame scheduler
interface qpsk_frame_scheduler_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic [1:0] m_dibit;
    logic       m_valid;
    logic       m_last;
    logic       m_ready;

    // master is the scheduler; slave is the byte source together with the mapper
    modport master (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_dibit, m_valid, m_last
    );
    modport slave (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_dibit, m_valid, m_last
    );
endinterface

// File: rtl/qpsk_frame_scheduler.sv
// rtl/qpsk_frame_scheduler.sv - frames payload bytes into preamble + dibit stream for the QPSK mapper
module qpsk_frame_scheduler #(
    parameter int          PRE_LEN    = 16,
    parameter logic [31:0] PRE_WORD   = 32'hCCCC3333,
    parameter int          GAP_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    qpsk_frame_scheduler_if.master bus,
    output logic                   busy,
    output logic [15:0]            frame_count
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} state_t;

    localparam logic [4:0] PRE_LAST = 5'(PRE_LEN - 1);
    localparam logic [7:0] GAP_INIT = 8'(GAP_CYCLES - 2);

    state_t     state;
    logic [4:0] pre_idx;
    logic [7:0] gap_cnt;
    logic [7:0] buf_data;
    logic       buf_last;
    logic       buf_full;
    logic [1:0] buf_idx;
    logic [1:0] m_dibit;
    logic       m_valid;
    logic       m_last;
    logic       xfer;
    logic       s_ready;
    logic       accept;

    function automatic logic [1:0] pre_dibit(input logic [4:0] k);
        logic [31:0] w;
        w = PRE_WORD << {k, 1'b0};
        return w[31:30];
    endfunction

    function automatic logic [1:0] byte_dibit(input logic [7:0] d, input logic [1:0] i);
        case (i)
            2'd0:    return d[7:6];
            2'd1:    return d[5:4];
            2'd2:    return d[3:2];
            default: return d[1:0];
        endcase
    endfunction

    assign xfer    = m_valid & bus.m_ready;
    // Next byte may land on the same edge the current byte's final dibit leaves.
    assign s_ready = (state == PAYLOAD) &
                     (!buf_full | ((buf_idx == 2'd3) & xfer & !buf_last));
    assign accept  = s_ready & bus.s_valid;

    assign bus.s_ready = s_ready;
    assign bus.m_dibit = m_dibit;
    assign bus.m_valid = m_valid;
    assign bus.m_last  = m_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pre_idx     <= '0;
            gap_cnt     <= '0;
            buf_data    <= '0;
            buf_last    <= 1'b0;
            buf_full    <= 1'b0;
            buf_idx     <= '0;
            m_dibit     <= '0;
            m_valid     <= 1'b0;
            m_last      <= 1'b0;
            busy        <= 1'b0;
            frame_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    m_last <= 1'b0;
                    if (bus.s_valid) begin
                        busy <= 1'b1;
                        if (PRE_LEN > 0) begin
                            state   <= PREAMBLE;
                            pre_idx <= '0;
                            m_dibit <= pre_dibit(5'd0);
                            m_valid <= 1'b1;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                end

                PREAMBLE: begin
                    if (xfer) begin
                        if (pre_idx == PRE_LAST) begin
                            state   <= PAYLOAD;
                            m_valid <= 1'b0;
                        end else begin
                            pre_idx <= pre_idx + 5'd1;
                            m_dibit <= pre_dibit(pre_idx + 5'd1);
                        end
                    end
                end

                PAYLOAD: begin
                    if (accept) begin
                        buf_data <= bus.s_data;
                        buf_last <= bus.s_last;
                        buf_full <= 1'b1;
                        buf_idx  <= 2'd0;
                        m_dibit  <= bus.s_data[7:6];
                        m_valid  <= 1'b1;
                        m_last   <= 1'b0;
                    end else if (xfer) begin
                        if (buf_idx == 2'd3) begin
                            buf_full <= 1'b0;
                            m_valid  <= 1'b0;
                            m_last   <= 1'b0;
                            if (buf_last) begin
                                frame_count <= frame_count + 16'd1;
                                // The IDLE cycle that precedes the next preamble is the final gap cycle.
                                if (GAP_CYCLES >= 2) begin
                                    state   <= GAP;
                                    gap_cnt <= GAP_INIT;
                                end else begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end
                        end else begin
                            buf_idx <= buf_idx + 2'd1;
                            m_dibit <= byte_dibit(buf_data, buf_idx + 2'd1);
                            m_last  <= buf_last & (buf_idx == 2'd2);
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt == 8'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qpsk_frame_scheduler.sv
// tb/tb_qpsk_frame_scheduler.sv - randomized self-checking bench for qpsk_frame_scheduler
module tb_qpsk_frame_scheduler;
    localparam int          A_PRE_LEN  = 2;
    localparam logic [31:0] A_PRE_WORD = 32'hC0000000;
    localparam int          A_GAP      = 4;

    logic        clk;
    logic        rst_n;
    logic        busy_a, busy_b;
    logic [15:0] fc_a, fc_b;

    qpsk_frame_scheduler_if ifa();
    qpsk_frame_scheduler_if ifb();

    qpsk_frame_scheduler #(.PRE_LEN(A_PRE_LEN), .PRE_WORD(A_PRE_WORD), .GAP_CYCLES(A_GAP)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa), .busy(busy_a), .frame_count(fc_a));
    qpsk_frame_scheduler #(.PRE_LEN(0), .PRE_WORD(32'h0), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb), .busy(busy_b), .frame_count(fc_b));

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          ready_mode = 0;
    logic [15:0] fc_exp = '0;
    logic [2:0]  exp_a[$];
    logic [2:0]  mon_a[$];
    logic        prev_stall;
    logic [3:0]  prev_out;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // mapper-side ready for dut_a: 0 always ready, 1 toggling, 2 random
    initial begin
        ifa.m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       ifa.m_ready = 1'b1;
                1:       ifa.m_ready = ~ifa.m_ready;
                default: ifa.m_ready = 1'($urandom_range(1));
            endcase
        end
    end

    initial begin
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk_cnt++;
                    if ({ifa.m_valid, ifa.m_last, ifa.m_dibit} !== prev_out)
                        $display("FAIL stall_hold got %b want %b", {ifa.m_valid, ifa.m_last, ifa.m_dibit}, prev_out);
                    else pass_cnt++;
                end
                if (ifa.m_valid && ifa.m_ready) mon_a.push_back({ifa.m_last, ifa.m_dibit});
                prev_stall = ifa.m_valid && !ifa.m_ready;
                prev_out   = {ifa.m_valid, ifa.m_last, ifa.m_dibit};
            end
        end
    end

    function automatic void model_frame(input logic [7:0] b[$]);
        for (int k = 0; k < A_PRE_LEN; k++)
            exp_a.push_back({1'b0, 2'((A_PRE_WORD >> (30 - 2 * k)) & 32'h3)});
        for (int i = 0; i < b.size(); i++)
            for (int j = 0; j < 4; j++)
                exp_a.push_back({(i == b.size() - 1) && (j == 3), 2'((b[i] >> (6 - 2 * j)) & 8'h3)});
    endfunction

    function automatic int stream_diff();
        for (int i = 0; i < exp_a.size(); i++)
            if (i >= mon_a.size() || mon_a[i] !== exp_a[i]) return i;
        if (mon_a.size() != exp_a.size()) return exp_a.size();
        return -1;
    endfunction

    function automatic void rand_frame(output logic [7:0] b[$], input int maxlen);
        int n;
        b.delete();
        n = $urandom_range(maxlen, 1);
        for (int i = 0; i < n; i++) b.push_back(8'($urandom));
    endfunction

    task automatic send_frame_a(input logic [7:0] b[$], input int idle_pct);
        logic acc;
        int   g;
        @(posedge clk); #1;
        for (int i = 0; i < b.size(); i++) begin
            while ($urandom_range(99) < idle_pct) begin
                ifa.s_valid = 1'b0;
                @(posedge clk); #1;
            end
            ifa.s_data  = b[i];
            ifa.s_last  = (i == b.size() - 1);
            ifa.s_valid = 1'b1;
            acc = 1'b0;
            g   = 0;
            while (!acc && g < 300) begin
                @(negedge clk);
                acc = ifa.s_ready;
                @(posedge clk); #1;
                g++;
            end
            if (!acc) begin
                chk_cnt++;
                $display("FAIL accept_timeout byte %0d got s_ready=0 want 1", i);
            end
        end
        ifa.s_valid = 1'b0;
        ifa.s_last  = 1'b0;
    endtask

    task automatic drain_a(output bit ok);
        int g = 0;
        while ((mon_a.size() < exp_a.size() || busy_a) && g < 4000) begin
            @(negedge clk);
            g++;
        end
        ok = (g < 4000);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if ({ifa.m_valid, ifa.m_last, ifa.m_dibit, ifa.s_ready, busy_a} !== 6'b0)
            $display("FAIL reset_outputs got %b want 000000", {ifa.m_valid, ifa.m_last, ifa.m_dibit, ifa.s_ready, busy_a});
        else pass_cnt++;
        chk_cnt++;
        if (fc_a !== 16'h0) $display("FAIL reset_count got %h want 0000", fc_a); else pass_cnt++;
        chk_cnt++;
        if ({ifb.m_valid, busy_b, fc_b} !== 18'h0) $display("FAIL reset_b got %h want 0", {ifb.m_valid, busy_b, fc_b});
        else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++;
        if ({ifa.m_valid, busy_a, ifa.s_ready} !== 3'b0) $display("FAIL idle_after_reset got %b want 000", {ifa.m_valid, busy_a, ifa.s_ready});
        else pass_cnt++;
    endtask

    task automatic test_single_byte;
        logic [7:0] b[$];
        bit ok;
        int d;
        ready_mode = 0;
        mon_a.delete();
        exp_a = '{3'b011, 3'b000, 3'b010, 3'b011, 3'b001, 3'b100};
        b = '{8'hB4};
        send_frame_a(b, 0);
        drain_a(ok);
        fc_exp++;
        chk_cnt++;
        if (!ok) $display("FAIL single_drain got %0d dibits want %0d", mon_a.size(), exp_a.size()); else pass_cnt++;
        d = stream_diff();
        chk_cnt++;
        if (d !== -1) $display("FAIL single_stream idx %0d got %b want %b", d, mon_a[d], exp_a[d]); else pass_cnt++;
        chk_cnt++;
        if (fc_a !== fc_exp) $display("FAIL single_count got %h want %h", fc_a, fc_exp); else pass_cnt++;
    endtask

    task automatic test_stall;
        logic [7:0] b[$];
        bit ok;
        int d;
        ready_mode = 1;
        mon_a.delete();
        exp_a = '{3'b011, 3'b000, 3'b010, 3'b011, 3'b001, 3'b100};
        b = '{8'hB4};
        send_frame_a(b, 0);
        drain_a(ok);
        fc_exp++;
        chk_cnt++;
        if (!ok) $display("FAIL stall_drain got %0d dibits want %0d", mon_a.size(), exp_a.size()); else pass_cnt++;
        d = stream_diff();
        chk_cnt++;
        if (d !== -1) $display("FAIL stall_stream idx %0d got %b want %b", d, mon_a[d], exp_a[d]); else pass_cnt++;
        chk_cnt++;
        if (fc_a !== fc_exp) $display("FAIL stall_count got %h want %h", fc_a, fc_exp); else pass_cnt++;
        ready_mode = 0;
    endtask

    task automatic test_no_preamble;
        logic [7:0] b[3] = '{8'h1B, 8'hE4, 8'hFF};
        logic [1:0] dib[12] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3};
        logic [2:0] got[$];
        int acc_cyc[$];
        int bi = 0, first = -1, last = -1, bad = -1;
        logic adv;
        @(posedge clk); #1;
        ifb.m_ready = 1'b1;
        ifb.s_data  = b[0];
        ifb.s_last  = 1'b0;
        ifb.s_valid = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (ifb.m_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                got.push_back({ifb.m_last, ifb.m_dibit});
            end
            adv = ifb.s_valid && ifb.s_ready;
            if (adv) acc_cyc.push_back(cyc);
            @(posedge clk); #1;
            if (adv) begin
                bi++;
                if (bi < 3) begin
                    ifb.s_data = b[bi];
                    ifb.s_last = (bi == 2);
                end else begin
                    ifb.s_valid = 1'b0;
                    ifb.s_last  = 1'b0;
                end
            end
        end
        chk_cnt++;
        if (got.size() !== 12 || last - first !== 11)
            $display("FAIL nopre_valid_run got %0d valid over span %0d want 12 over 11", got.size(), last - first);
        else pass_cnt++;
        for (int i = 0; i < 12 && i < got.size(); i++)
            if (bad < 0 && got[i] !== {i == 11, dib[i]}) bad = i;
        chk_cnt++;
        if (bad !== -1) $display("FAIL nopre_stream idx %0d got %b want %b", bad, got[bad], {bad == 11, dib[bad]});
        else pass_cnt++;
        chk_cnt++;
        if (acc_cyc.size() !== 3 || acc_cyc[1] - acc_cyc[0] !== 4 || acc_cyc[2] - acc_cyc[1] !== 4)
            $display("FAIL nopre_s_ready got %0d accepts want 3 spaced by 4", acc_cyc.size());
        else pass_cnt++;
        chk_cnt++;
        if (fc_b !== 16'd1) $display("FAIL nopre_count got %h want 0001", fc_b); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [7:0] f1[$], f2[$];
        int zeros = 0, g = 0, d;
        bit seen = 0, ok;
        logic busy_gap = 1'b0;
        ready_mode = 0;
        mon_a.delete();
        exp_a.delete();
        rand_frame(f1, 3);
        rand_frame(f2, 3);
        model_frame(f1);
        model_frame(f2);
        fork
            begin
                send_frame_a(f1, 0);
                send_frame_a(f2, 0);
            end
            begin
                while (!seen && g < 500) begin
                    @(negedge clk);
                    seen = ifa.m_valid && ifa.m_ready && ifa.m_last;
                    g++;
                end
                g = 0;
                @(negedge clk);
                busy_gap = busy_a;
                while (!ifa.m_valid && g < 100) begin
                    zeros++;
                    @(negedge clk);
                    g++;
                end
            end
        join
        drain_a(ok);
        fc_exp += 16'd2;
        chk_cnt++;
        if (zeros !== A_GAP) $display("FAIL b2b_gap got %0d idle cycles want %0d", zeros, A_GAP); else pass_cnt++;
        chk_cnt++;
        if (busy_gap !== 1'b1) $display("FAIL b2b_busy_in_gap got %b want 1", busy_gap); else pass_cnt++;
        d = stream_diff();
        chk_cnt++;
        if (!ok || d !== -1) $display("FAIL b2b_stream idx %0d got %b want %b", d, mon_a[d], exp_a[d]); else pass_cnt++;
        chk_cnt++;
        if (fc_a !== fc_exp) $display("FAIL b2b_count got %h want %h", fc_a, fc_exp); else pass_cnt++;
    endtask

    task automatic test_random_frames;
        logic [7:0] b[$];
        bit ok;
        int d;
        ready_mode = 2;
        mon_a.delete();
        exp_a.delete();
        for (int f = 0; f < 8; f++) begin
            rand_frame(b, 5);
            model_frame(b);
            send_frame_a(b, 30);
            fc_exp++;
        end
        drain_a(ok);
        d = stream_diff();
        chk_cnt++;
        if (!ok || d !== -1) $display("FAIL random_stream idx %0d got %b want %b", d, mon_a[d], exp_a[d]); else pass_cnt++;
        chk_cnt++;
        if (fc_a !== fc_exp) $display("FAIL random_count got %h want %h", fc_a, fc_exp); else pass_cnt++;
        ready_mode = 0;
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b[$];
        int acc = 0, g = 0, d;
        bit ok;
        ready_mode = 0;
        b.delete();
        for (int i = 0; i < 4; i++) b.push_back(8'($urandom));
        @(posedge clk); #1;
        ifa.s_data  = b[0];
        ifa.s_last  = 1'b0;
        ifa.s_valid = 1'b1;
        while (acc < 2 && g < 300) begin
            @(negedge clk);
            if (ifa.s_valid && ifa.s_ready) acc++;
            @(posedge clk); #1;
            ifa.s_data = b[acc];
            ifa.s_last = (acc == 3);
            g++;
        end
        ifa.s_valid = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({busy_a, ifa.m_valid} !== 2'b11) $display("FAIL mid_active got %b want 11", {busy_a, ifa.m_valid}); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({ifa.m_valid, ifa.m_last, ifa.m_dibit, ifa.s_ready, busy_a} !== 6'b0)
            $display("FAIL mid_reset_outputs got %b want 000000", {ifa.m_valid, ifa.m_last, ifa.m_dibit, ifa.s_ready, busy_a});
        else pass_cnt++;
        chk_cnt++;
        if (fc_a !== 16'h0) $display("FAIL mid_reset_count got %h want 0000", fc_a); else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        fc_exp = '0;
        mon_a.delete();
        exp_a.delete();
        rand_frame(b, 3);
        model_frame(b);
        send_frame_a(b, 0);
        drain_a(ok);
        fc_exp++;
        d = stream_diff();
        chk_cnt++;
        if (!ok || d !== -1) $display("FAIL post_reset_stream idx %0d got %b want %b", d, mon_a[d], exp_a[d]); else pass_cnt++;
        chk_cnt++;
        if (fc_a !== fc_exp) $display("FAIL post_reset_count got %h want %h", fc_a, fc_exp); else pass_cnt++;
    endtask

    task automatic test_count_wrap;
        logic [7:0] b[$];
        bit ok;
        @(posedge clk); #1;
        force dut_a.frame_count = 16'hFFFF;
        #2;
        release dut_a.frame_count;
        fc_exp = 16'hFFFF;
        mon_a.delete();
        exp_a.delete();
        rand_frame(b, 2);
        model_frame(b);
        send_frame_a(b, 0);
        drain_a(ok);
        fc_exp++;
        chk_cnt++;
        if (!ok || fc_a !== fc_exp) $display("FAIL count_wrap got %h want %h", fc_a, fc_exp); else pass_cnt++;
    endtask

    initial begin
        rst_n       = 1'b0;
        ifa.s_data  = '0;
        ifa.s_valid = 1'b0;
        ifa.s_last  = 1'b0;
        ifb.s_data  = '0;
        ifb.s_valid = 1'b0;
        ifb.s_last  = 1'b0;
        ifb.m_ready = 1'b1;
        test_reset();
        test_single_byte();
        test_stall();
        test_no_preamble();
        test_back_to_back();
        test_random_frames();
        test_reset_mid_frame();
        test_count_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
